// File: rtl/im_boot_pkg.sv
// im_boot_pkg: shared state encodings and defaults for the boot-loadable instruction memory.
package im_boot_pkg;
   typedef enum logic {IM_LOAD = 1'b0, IM_RUN = 1'b1} im_state_t;
   localparam logic [31:0] IM_BASE_ADDR = 32'h00003000;
   localparam logic [31:0] IM_NOP = 32'h0;
endpackage

// File: rtl/im_boot_if.sv
// im_boot_if: fetch read port plus byte-serial loader port; checksum appears with IM_CHECKSUM_EN.
interface im_boot_if #(parameter int DEPTH_LOG2 = 10);
   logic [31:0] pc;
   logic [31:0] instr;
   logic addr_fault;
   logic ld_valid;
   logic [7:0] ld_byte;
   logic ld_ready;
   logic ld_done;
   logic cpu_hold;
   logic [DEPTH_LOG2:0] word_count;
`ifdef IM_CHECKSUM_EN
   logic [31:0] checksum;
`endif
   modport slave (
      input pc, ld_valid, ld_byte, ld_done,
      output
`ifdef IM_CHECKSUM_EN
      checksum,
`endif
      instr, addr_fault, ld_ready, cpu_hold, word_count
   );
   modport master (
      output pc, ld_valid, ld_byte, ld_done,
      input
`ifdef IM_CHECKSUM_EN
      checksum,
`endif
      instr, addr_fault, ld_ready, cpu_hold, word_count
   );
endinterface

// File: rtl/im_byte_packer.sv
// im_byte_packer: packs big-endian bytes into 32-bit words; flush emits a zero-padded partial word.
module im_byte_packer (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        accept,
   input  logic        flush,
   input  logic [7:0]  data,
   output logic        word_valid,
   output logic [31:0] word
);
   logic [1:0]  bidx;
   logic [31:0] pack;
   // the byte accepted this cycle is merged so a completing or flushed word includes it
   always_comb begin
      word = accept ? (pack | ({data, 24'h0} >> {bidx, 3'b000})) : pack;
      word_valid = (accept && bidx == 2'd3) || (flush && (accept || bidx != 2'd0));
   end
   always_ff @(posedge Clk) begin
      if (Reset || word_valid || flush) begin
         bidx <= 2'd0;
         pack <= 32'h0;
      end else if (accept) begin
         bidx <= bidx + 2'd1;
         pack <= word;
      end
   end
endmodule

// File: rtl/im_boot.sv
// im_boot: instruction memory with combinational fetch read and a byte-serial boot loader holding the core.
// Optional IM_CHECKSUM_EN adds a running sum of every written word.
module im_boot
   import im_boot_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = IM_BASE_ADDR
) (
   input logic Clk,
   input logic Reset,
   im_boot_if.slave bus
);
   localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);
   im_state_t state, state_n;
   logic [DEPTH_LOG2:0]   wptr;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0] mem [2**DEPTH_LOG2];
   logic [31:0] word;
   logic word_valid, accept, flush, fault;
   always_comb begin
      state_n = (state == IM_LOAD && (bus.ld_done || wptr == FULL)) ? IM_RUN : state;
      bus.ld_ready = state == IM_LOAD && wptr != FULL;
      accept = bus.ld_valid && bus.ld_ready && !Reset;
      flush = state == IM_LOAD && bus.ld_done && !Reset;
   end
   always_ff @(posedge Clk) state <= Reset ? IM_LOAD : state_n;
   im_byte_packer u_packer (
      .Clk(Clk), .Reset(Reset), .accept(accept), .flush(flush),
      .data(bus.ld_byte), .word_valid(word_valid), .word(word)
   );
   always_ff @(posedge Clk) begin
      if (Reset) wptr <= '0;
      else if (word_valid) wptr <= wptr + 1'b1;
   end
   always_ff @(posedge Clk) if (word_valid) mem[wptr[DEPTH_LOG2-1:0]] <= word;
   // stale words from an aborted load stay in the array; the word_count compare hides them
   always_comb begin
      idx = bus.pc[DEPTH_LOG2+1:2];
      fault = bus.pc[1:0] != 2'b00 || bus.pc < BASE_ADDR || {1'b0, bus.pc} >= LIMIT;
      bus.addr_fault = state == IM_RUN && fault;
      bus.instr = (state == IM_RUN && !fault && {1'b0, idx} < wptr) ? mem[idx] : IM_NOP;
      bus.cpu_hold = state != IM_RUN;
      bus.word_count = wptr;
   end
`ifdef IM_CHECKSUM_EN
   logic [31:0] sum;
   always_ff @(posedge Clk) begin
      if (Reset) sum <= 32'h0;
      else if (word_valid) sum <= sum + word;
   end
   assign bus.checksum = sum;
`endif
endmodule

// File: tb/tb_im_boot.sv
// tb_im_boot: directed self-checking bench for im_boot (define IM_CHECKSUM_EN to also check checksum).
module tb_im_boot;
   logic Clk = 1'b0;
   logic Reset = 1'b0;
   int errors = 0;
   int checks = 0;
   im_boot_if #(.DEPTH_LOG2(10)) bus ();
   im_boot #(.DEPTH_LOG2(10), .BASE_ADDR(32'h00003000)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      bus.ld_valid = 1'b0;
      bus.ld_done = 1'b0;
      step();
      Reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic done);
      bus.ld_valid = 1'b1;
      bus.ld_byte = b;
      bus.ld_done = done;
      step();
      bus.ld_valid = 1'b0;
      bus.ld_done = 1'b0;
   endtask

   task automatic done_pulse();
      bus.ld_done = 1'b1;
      step();
      bus.ld_done = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      bus.pc = 32'h3000;
      #1;
      checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold got=%b exp=1", bus.cpu_hold); end
      checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.ld_ready); end
      checks++; if (bus.word_count !== 11'd0) begin errors++; $display("FAIL rst_wc got=%0d exp=0", bus.word_count); end
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", bus.instr); end
      bus.pc = 32'h3002;
      #1;
      checks++; if (bus.addr_fault !== 1'b0) begin errors++; $display("FAIL load_fault got=%b exp=0", bus.addr_fault); end
   endtask

   task automatic test_word();
      do_reset();
      send(8'h3C, 1'b0); send(8'h01, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
      bus.pc = 32'h3000;
      #1;
      checks++; if (bus.word_count !== 11'd1) begin errors++; $display("FAIL word_wc got=%0d exp=1", bus.word_count); end
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL word_load_instr got=%h exp=0", bus.instr); end
      bus.ld_done = 1'b1;
      #1;
      checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL word_hold_pre got=%b exp=1", bus.cpu_hold); end
      step();
      bus.ld_done = 1'b0;
      #1;
      checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL word_hold_post got=%b exp=0", bus.cpu_hold); end
      checks++; if (bus.instr !== 32'h3C011234) begin errors++; $display("FAIL word_instr got=%h exp=3c011234", bus.instr); end
      checks++; if (bus.word_count !== 11'd1) begin errors++; $display("FAIL word_wc_run got=%0d exp=1", bus.word_count); end
`ifdef IM_CHECKSUM_EN
      checks++; if (bus.checksum !== 32'h3C011234) begin errors++; $display("FAIL word_sum got=%h exp=3c011234", bus.checksum); end
`endif
   endtask

   task automatic test_partial();
      do_reset();
      send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0); send(8'hEE, 1'b0);
      done_pulse();
      bus.pc = 32'h3004;
      #1;
      checks++; if (bus.word_count !== 11'd2) begin errors++; $display("FAIL part_wc got=%0d exp=2", bus.word_count); end
      checks++; if (bus.instr !== 32'hEE000000) begin errors++; $display("FAIL part_instr1 got=%h exp=ee000000", bus.instr); end
      bus.pc = 32'h3000;
      #1;
      checks++; if (bus.instr !== 32'hAABBCCDD) begin errors++; $display("FAIL part_instr0 got=%h exp=aabbccdd", bus.instr); end
      bus.pc = 32'h3008;
      #1;
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL part_beyond got=%h exp=0", bus.instr); end
`ifdef IM_CHECKSUM_EN
      checks++; if (bus.checksum !== 32'h98BBCCDD) begin errors++; $display("FAIL part_sum got=%h exp=98bbccdd", bus.checksum); end
`endif
   endtask

   task automatic test_done_with_last();
      do_reset();
      send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b1);
      bus.pc = 32'h3000;
      #1;
      checks++; if (bus.word_count !== 11'd1) begin errors++; $display("FAIL last_wc got=%0d exp=1", bus.word_count); end
      checks++; if (bus.instr !== 32'h12345678) begin errors++; $display("FAIL last_instr got=%h exp=12345678", bus.instr); end
      checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL last_ready got=%b exp=0", bus.ld_ready); end
   endtask

   task automatic test_done_mid_byte();
      do_reset();
      send(8'h01, 1'b0); send(8'h02, 1'b1);
      bus.pc = 32'h3000;
      #1;
      checks++; if (bus.word_count !== 11'd1) begin errors++; $display("FAIL mid_wc got=%0d exp=1", bus.word_count); end
      checks++; if (bus.instr !== 32'h01020000) begin errors++; $display("FAIL mid_instr got=%h exp=01020000", bus.instr); end
      send(8'h55, 1'b1);
      checks++; if (bus.word_count !== 11'd1) begin errors++; $display("FAIL run_ignore_wc got=%0d exp=1", bus.word_count); end
      checks++; if (bus.instr !== 32'h01020000) begin errors++; $display("FAIL run_ignore_instr got=%h exp=01020000", bus.instr); end
   endtask

   task automatic test_fault();
      logic [31:0] pcs [4] = '{32'h3002, 32'h2FFC, 32'h4000, 32'h3FFC};
      logic        exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         bus.pc = pcs[i];
         #1;
         checks++; if (bus.addr_fault !== exp[i]) begin errors++; $display("FAIL fault pc=%h got=%b exp=%b", pcs[i], bus.addr_fault, exp[i]); end
         checks++; if (exp[i] && bus.instr !== 32'h0) begin errors++; $display("FAIL fault_instr pc=%h got=%h exp=0", pcs[i], bus.instr); end
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4096; i++) send(8'(i), 1'b0);
      checks++; if (bus.word_count !== 11'd1024) begin errors++; $display("FAIL full_wc got=%0d exp=1024", bus.word_count); end
      checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.ld_ready); end
      checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL full_hold_pre got=%b exp=1", bus.cpu_hold); end
      send(8'h99, 1'b0);
      send(8'h98, 1'b0);
      checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL full_auto_run got=%b exp=0", bus.cpu_hold); end
      checks++; if (bus.word_count !== 11'd1024) begin errors++; $display("FAIL full_wc_held got=%0d exp=1024", bus.word_count); end
      bus.pc = 32'h3FFC;
      #1;
      checks++; if (bus.instr !== 32'hFCFDFEFF) begin errors++; $display("FAIL full_last got=%h exp=fcfdfeff", bus.instr); end
      bus.pc = 32'h3000;
      #1;
      checks++; if (bus.instr !== 32'h00010203) begin errors++; $display("FAIL full_first got=%h exp=00010203", bus.instr); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h99, 1'b0); send(8'h88, 1'b0);
      do_reset();
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
      done_pulse();
      bus.pc = 32'h3000;
      #1;
      checks++; if (bus.word_count !== 11'd1) begin errors++; $display("FAIL rmid_wc got=%0d exp=1", bus.word_count); end
      checks++; if (bus.instr !== 32'h11223344) begin errors++; $display("FAIL rmid_instr got=%h exp=11223344", bus.instr); end
      bus.pc = 32'h3004;
      #1;
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rmid_stale got=%h exp=0", bus.instr); end
`ifdef IM_CHECKSUM_EN
      checks++; if (bus.checksum !== 32'h11223344) begin errors++; $display("FAIL rmid_sum got=%h exp=11223344", bus.checksum); end
`endif
   endtask

   initial begin
      bus.pc = 32'h3000;
      bus.ld_valid = 1'b0;
      bus.ld_byte = 8'h0;
      bus.ld_done = 1'b0;
      test_reset();
      test_word();
      test_partial();
      test_done_with_last();
      test_done_mid_byte();
      test_fault();
      test_full();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
